// File: rtl/switch_debounce.sv
// Two-flop synchronizer, per-bit stability debounce and a registered summary
// (highest set index, non-zero, one-hot) of the debounced switch word.
module switch_debounce #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] LED,
  output logic             sw_changed,
  output logic [3:0]       sw_index,
  output logic             sw_nonzero,
  output logic             sw_onehot
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_led;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic             r_changed;
  logic [3:0]       r_index;
  logic             r_nonzero;
  logic             r_onehot;

  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_led_next;
  logic [3:0]       w_index;
  logic             w_nonzero;
  logic             w_onehot;

  // A bit flips only after STABLE_CYCLES consecutive edges of disagreement;
  // any agreement in between drops the count back to zero.
  always_comb begin
    w_led_next = r_led;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_led[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_led_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Summary is decoded from the next LED value so it lands on the same edge.
  always_comb begin
    w_index = 4'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_led_next[i]) begin
        w_index = i[3:0];
      end
    end
    w_nonzero = |w_led_next;
    w_onehot  = w_nonzero && ((w_led_next & (w_led_next - WIDTH'(1))) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_led     <= '0;
      r_changed <= 1'b0;
      r_index   <= 4'd0;
      r_nonzero <= 1'b0;
      r_onehot  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= SW;
      r_s2      <= r_s1;
      r_led     <= w_led_next;
      r_changed <= (w_led_next != r_led);
      r_index   <= w_index;
      r_nonzero <= w_nonzero;
      r_onehot  <= w_onehot;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Level outputs, no handshake: consumers may sample LED at any time.
  assign LED        = r_led;
  assign sw_changed = r_changed;
  assign sw_index   = r_index;
  assign sw_nonzero = r_nonzero;
  assign sw_onehot  = r_onehot;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random switch activity,
// checked against a sliding-window model of the debounce rule.
module tb_switch_debounce;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] SW;
  logic [W-1:0] LED;
  logic         sw_changed;
  logic [3:0]   sw_index;
  logic         sw_nonzero;
  logic         sw_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_led;
  logic         m_chg, m_nz, m_oh;
  logic [3:0]   m_idx;
  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .SW         (SW),
    .LED        (LED),
    .sw_changed (sw_changed),
    .sw_index   (sw_index),
    .sw_nonzero (sw_nonzero),
    .sw_onehot  (sw_onehot)
  );

  function automatic logic [3:0] hi_index(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return i[3:0];
    end
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_s1  = '0;
    m_s2  = '0;
    m_led = '0;
    m_chg = 1'b0;
    m_idx = 4'd0;
    m_nz  = 1'b0;
    m_oh  = 1'b0;
    hist.delete();
  endtask

  // Drive SW, advance one edge, update the model, then settle 1 time unit.
  // A bit flips when the last S synchronized samples all disagree with it.
  task automatic tick(input logic [W-1:0] sw);
    logic [W-1:0] nl;
    logic         all_diff;
    SW = sw;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      nl = m_led;
      hist.push_back(m_s2);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_led[b]) all_diff = 1'b0;
          if (all_diff) nl[b] = ~m_led[b];
        end
      end
      m_chg = (nl != m_led);
      m_led = nl;
      m_idx = hi_index(nl);
      m_nz  = (nl != '0);
      m_oh  = ($countones(nl) == 1);
      m_s2  = m_s1;
      m_s1  = sw;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    SW  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got led=%h chg=%b idx=%0d nz=%b oh=%b, want all 0",
               LED, sw_changed, sw_index, sw_nonzero, sw_onehot);
    end
    n_tests++;
    rst = 1'b0;
  endtask

  task automatic test_walking_one();
    logic [W-1:0] v, prev;
    int           pulses;
    prev = '0;
    for (int k = -1; k < W; k++) begin
      v = (k < 0) ? '0 : (W'(1) << k);
      pulses = 0;
      for (int t = 1; t <= 10; t++) begin
        tick(v);
        if (sw_changed) pulses++;
        if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== {m_led, m_chg, m_idx, m_nz, m_oh}) begin
          n_fail++;
          $display("FAIL walk_model k=%0d t=%0d: got led=%h chg=%b idx=%0d nz=%b oh=%b, want led=%h chg=%b idx=%0d nz=%b oh=%b",
                   k, t, LED, sw_changed, sw_index, sw_nonzero, sw_onehot, m_led, m_chg, m_idx, m_nz, m_oh);
        end
        n_tests++;
        if (t == 6) begin
          if (LED !== v || sw_index !== ((k < 0) ? 4'd0 : 4'(k)) || sw_onehot !== (k >= 0) || sw_nonzero !== (k >= 0)) begin
            n_fail++;
            $display("FAIL walk_latency k=%0d: got led=%h idx=%0d oh=%b nz=%b, want led=%h at 6th edge",
                     k, LED, sw_index, sw_onehot, sw_nonzero, v);
          end
          n_tests++;
        end
      end
      if (pulses != ((v != prev) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL walk_pulses k=%0d: got %0d pulses, want %0d", k, pulses, (v != prev) ? 1 : 0);
      end
      n_tests++;
      prev = v;
    end
  endtask

  task automatic test_glitch_reject();
    logic [W-1:0] pat[$];
    int           bad;
    repeat (10) tick('0);
    pat = {16'h0020, 16'h0020, 16'h0020};
    repeat (10) pat.push_back('0);
    pat = {pat, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0020, 16'h0020};
    repeat (10) pat.push_back('0);
    bad = 0;
    foreach (pat[i]) begin
      tick(pat[i]);
      if (LED !== '0 || sw_changed !== 1'b0) bad++;
      if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== {m_led, m_chg, m_idx, m_nz, m_oh}) begin
        n_fail++;
        $display("FAIL glitch_model i=%0d: got led=%h chg=%b, want led=%h chg=%b", i, LED, sw_changed, m_led, m_chg);
      end
      n_tests++;
    end
    if (bad != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: got %0d cycles with led/chg active, want 0", bad);
    end
    n_tests++;
  endtask

  task automatic test_glitch_accept();
    int pulses, hi_cycles;
    pulses = 0;
    hi_cycles = 0;
    for (int t = 0; t < 16; t++) begin
      tick((t < 4) ? 16'h0020 : 16'h0000);
      if (sw_changed) pulses++;
      if (LED === 16'h0020) hi_cycles++;
      if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== {m_led, m_chg, m_idx, m_nz, m_oh}) begin
        n_fail++;
        $display("FAIL accept_model t=%0d: got led=%h chg=%b idx=%0d, want led=%h chg=%b idx=%0d",
                 t, LED, sw_changed, sw_index, m_led, m_chg, m_idx);
      end
      n_tests++;
    end
    if (pulses != 2 || hi_cycles != 4) begin
      n_fail++;
      $display("FAIL glitch_accept: got pulses=%0d high_cycles=%0d, want 2 and 4", pulses, hi_cycles);
    end
    n_tests++;
  endtask

  task automatic test_multi_bit();
    int pulses;
    pulses = 0;
    repeat (10) begin
      tick(16'hFFFF);
      if (sw_changed) pulses++;
    end
    if (pulses != 1 || LED !== 16'hFFFF || sw_index !== 4'd15 || sw_onehot !== 1'b0 || sw_nonzero !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_ffff: got pulses=%0d led=%h idx=%0d oh=%b nz=%b, want 1 ffff 15 0 1",
               pulses, LED, sw_index, sw_onehot, sw_nonzero);
    end
    n_tests++;
    repeat (10) tick(16'h0081);
    if (LED !== 16'h0081 || sw_index !== 4'd7 || sw_onehot !== 1'b0 || sw_nonzero !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_0081: got led=%h idx=%0d oh=%b nz=%b, want 0081 7 0 1",
               LED, sw_index, sw_onehot, sw_nonzero);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_count();
    int pulses;
    repeat (3) tick(16'h0010);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got led=%h chg=%b idx=%0d nz=%b oh=%b, want all 0",
               LED, sw_changed, sw_index, sw_nonzero, sw_onehot);
    end
    n_tests++;
    repeat (2) tick(16'h0010);
    rst = 1'b0;
    pulses = 0;
    for (int t = 1; t <= 10; t++) begin
      tick(16'h0010);
      if (sw_changed) pulses++;
      if (t == 5 && LED !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_early: got led=%h at 5th edge, want 0000", LED);
      end
      if (t == 5) n_tests++;
      if (t == 6) begin
        if (LED !== 16'h0010 || sw_changed !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_release: got led=%h chg=%b at 6th edge, want 0010 1", LED, sw_changed);
        end
        n_tests++;
      end
    end
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reset_pulses: got %0d, want 1", pulses);
    end
    n_tests++;
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    v = LED;
    for (int seg = 0; seg < 250; seg++) begin
      case ($urandom_range(0, 3))
        0:       v = v ^ (W'(1) << $urandom_range(0, W - 1));
        1:       v = W'($urandom);
        default: v = v ^ W'($urandom_range(0, 7));
      endcase
      repeat ($urandom_range(1, 7)) begin
        tick(v);
        if ({LED, sw_changed, sw_index, sw_nonzero, sw_onehot} !== {m_led, m_chg, m_idx, m_nz, m_oh}) begin
          n_fail++;
          $display("FAIL random seg=%0d: got led=%h chg=%b idx=%0d nz=%b oh=%b, want led=%h chg=%b idx=%0d nz=%b oh=%b",
                   seg, LED, sw_changed, sw_index, sw_nonzero, sw_onehot, m_led, m_chg, m_idx, m_nz, m_oh);
        end
        n_tests++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    SW  = '0;
    test_reset();
    test_walking_one();
    test_glitch_reject();
    test_glitch_accept();
    test_multi_bit();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
